mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter and sequencer in front of the single-port 1K×16 `memory` block. It shares that memory between the instruction-fetch port (read-only) and the load/store port (read/write). It converts each port's req/ack handshake into correctly timed `addr`/`write_en`/`read_en` strobes, and it owns the bidirectional `data` bus. It sits between the CPU core and `memory`, and it is the only driver of the memory control pins.

## Interface
- `ADDR_W`, default 10: memory address width.
- `DATA_W`, default 16: memory word width.
- `READ_LAT`, default 1: cycles from the clock edge that samples `read_en` until `data` is valid. Range ≥1.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `if_req`  in  1: fetch read request. Held until `if_ack`.
- `if_addr`  in  ADDR_W: fetch address.
- `if_ack`  out  1: one-cycle completion pulse for fetch.
- `if_rdata`  out  DATA_W: fetch read data. Valid while `if_ack` is high; held until the next `if_ack`.
- `ls_req`  in  1: load/store request. Held until `ls_ack`.
- `ls_we`  in  1: 1 = store, 0 = load.
- `ls_addr`  in  ADDR_W: load/store address.
- `ls_wdata`  in  DATA_W: store data.
- `ls_ack`  out  1: one-cycle completion pulse for load/store.
- `ls_rdata`  out  DATA_W: load data. Valid while `ls_ack` is high; held until the next `ls_ack`.
- `mem_addr`  out  ADDR_W: to `memory.addr`. Registered.
- `mem_write_en`  out  1: to `memory.write_en`. Registered.
- `mem_read_en`  out  1: to `memory.read_en`. Registered.
- `mem_data`  inout  DATA_W: to `memory.data`. Driven only while `mem_write_en`=1, otherwise high-Z.

## Operation
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE: sample `if_req` and `ls_req`.
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port that did not receive the previous grant (round-robin via `last_grant`).
- On grant, latch the granted port's address, `we`, wdata and port id. Requester inputs are ignored from then until its ack.
- Next state after grant: WRITE for a store, READ for a load or fetch.
- WRITE, one cycle:
  - `mem_write_en`=1 and `mem_addr`=latched address.
  - `mem_data` driven with the latched wdata.
  - Memory writes on the closing edge. Next state DONE.
- READ, READ_LAT+1 cycles:
  - `mem_read_en`=1 and `mem_addr` stable for the whole interval.
  - A wait counter counts the cycles.
  - On the final edge, capture `mem_data` into the granted port's rdata register. Next state DONE.
- DONE, one cycle:
  - Granted port's ack=1; `mem_read_en`=0 and `mem_write_en`=0.
  - Update `last_grant`. Next state IDLE.
  - Requests are not sampled in DONE. The requester drops `req`, or presents a new request, in this cycle.
- `mem_write_en` and `mem_read_en` are never high together.
- `if_ack` and `ls_ack` are never high together.
- `mem_addr` holds its last value in IDLE.

## Timing
- Reset (`rst`=1 at an edge) sets, from the next cycle:
  - state=IDLE, `mem_write_en`=0, `mem_read_en`=0, `mem_addr`=0, `mem_data`=Z;
  - `if_ack`=`ls_ack`=0, `if_rdata`=`ls_rdata`=0;
  - `last_grant`=IF, so LS wins the first tie.
- Store latency: request seen in IDLE at edge N. WRITE is cycle N+1; memory writes at edge N+1. `ls_ack` is high in cycle N+2.
- Read latency: request seen at edge N. READ occupies cycles N+1 … N+1+READ_LAT. Ack and valid rdata in cycle N+2+READ_LAT, which is 3 cycles after the request for READ_LAT=1.
- Back-to-back: a request held through DONE is re-arbitrated in IDLE the cycle after. Minimum period is 3 cycles per store and READ_LAT+3 per read.
- Under continuous dual requests, grants alternate strictly IF/LS. Neither port starves.
- Reset mid-operation: the in-flight transfer is aborted with no ack, and strobes drop the cycle after the reset edge. If `rst` coincides with the closing edge of WRITE, the memory write still completes but is not acked. The requester reissues after reset.
- Address wrap: none. Addresses are used as-is; 10'h3FF is valid.

## Structure
- `mem_arb_pkg` holds:
  - state enum (IDLE/WRITE/READ/DONE);
  - port-id constants PORT_IF=0, PORT_LS=1;
  - default widths ADDR_W=10 and DATA_W=16.
- Sub-module `rr_arb2`: combinational two-requester round-robin grant from `if_req`, `ls_req` and `last_grant`. `mem_arbiter` instantiates it in IDLE.
- Tristate assign on `mem_data` lives in the top module only.

## Test plan
- Reset: assert `rst` 2 cycles → all strobes 0, `mem_data`=Z, both acks 0, both rdata 16'h0000.
- LS store then load: store 16'hAAAA @10'h100, then load @10'h100 → `mem_write_en` for exactly 1 cycle; `ls_ack` 2 cycles after store req; load ack 3 cycles after req with `ls_rdata`=16'hAAAA.
- Fetch read: preload 16'hBBBB @10'h101 via LS, then `if_req` @10'h101 → `if_ack` with `if_rdata`=16'hBBBB; `ls_rdata` unchanged.
- Simultaneous requests after reset: both req @10'h102/10'h103 held → LS granted first, IF next; acks alternate for 6 consecutive transfers.
- Reset mid-read: `rst` in the 2nd READ cycle → no ack; `mem_read_en`=0 the next cycle; re-issued read returns the correct data.
- Boundary address and bus ownership: store 16'hCCCC @10'h3FF then read → 16'hCCCC; checker flags any cycle where `mem_data` is driven while `mem_write_en`=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: FSM state encoding,
// port identifiers and default bus widths.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_LS = 1'b1;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: on a tie the port that did not win last
// time is chosen, so neither fetch nor load/store can starve the other.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic if_req,
   input  logic ls_req,
   input  logic last_grant,
   output logic gnt_vld,
   output logic gnt_port
);

   always_comb begin
      gnt_vld  = if_req | ls_req;
      gnt_port = PORT_IF;
      if (if_req && ls_req) begin
         gnt_port = ~last_grant;
      end else if (ls_req) begin
         gnt_port = PORT_LS;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port memory between instruction fetch (read-only) and
// load/store, sequencing registered addr/strobe pins and owning the data bus.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | arbitrate; on grant latch addr/we/wdata/port
// ST_WRITE | one cycle, write strobe high, bus driven with latched wdata
// ST_READ  | READ_LAT+1 cycles, read strobe high, capture data on last edge
// ST_DONE  | one-cycle ack to the granted port, update round-robin pointer
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_ack,
   output logic [DATA_W-1:0] ls_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write_en,
   output logic              mem_read_en,
   inout  wire  [DATA_W-1:0] mem_data
);

   localparam int CNT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);

   state_e            state_q, state_d;
   logic              port_q, port_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_write_en_q, mem_write_en_d;
   logic              mem_read_en_q, mem_read_en_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
   logic              gnt_vld, gnt_port;

   rr_arb2 u_rr_arb2 (
      .if_req     (if_req),
      .ls_req     (ls_req),
      .last_grant (last_grant_q),
      .gnt_vld    (gnt_vld),
      .gnt_port   (gnt_port)
   );

   always_comb begin
      state_d        = state_q;
      port_d         = port_q;
      we_d           = we_q;
      wdata_d        = wdata_q;
      cnt_d          = cnt_q;
      last_grant_d   = last_grant_q;
      mem_addr_d     = mem_addr_q;
      mem_write_en_d = 1'b0;
      mem_read_en_d  = 1'b0;
      if_rdata_d     = if_rdata_q;
      ls_rdata_d     = ls_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               port_d = gnt_port;
               we_d   = (gnt_port == PORT_LS) && ls_we;
               cnt_d  = CNT_W'(READ_LAT);
               if (gnt_port == PORT_LS) begin
                  mem_addr_d = ls_addr;
                  wdata_d    = ls_wdata;
               end else begin
                  mem_addr_d = if_addr;
               end
               if (we_d) begin
                  state_d        = ST_WRITE;
                  mem_write_en_d = 1'b1;
               end else begin
                  state_d       = ST_READ;
                  mem_read_en_d = 1'b1;
               end
            end
         end
         ST_WRITE: state_d = ST_DONE;
         ST_READ: begin
            // Down-counter reaching zero marks the edge where memory data is valid.
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               if (port_q == PORT_IF) begin
                  if_rdata_d = mem_data;
               end else begin
                  ls_rdata_d = mem_data;
               end
            end else begin
               cnt_d         = cnt_q - CNT_W'(1);
               mem_read_en_d = 1'b1;
            end
         end
         ST_DONE: begin
            last_grant_d = port_q;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         port_q         <= PORT_IF;
         we_q           <= 1'b0;
         wdata_q        <= '0;
         cnt_q          <= '0;
         last_grant_q   <= PORT_IF;
         mem_addr_q     <= '0;
         mem_write_en_q <= 1'b0;
         mem_read_en_q  <= 1'b0;
         if_rdata_q     <= '0;
         ls_rdata_q     <= '0;
      end else begin
         state_q        <= state_d;
         port_q         <= port_d;
         we_q           <= we_d;
         wdata_q        <= wdata_d;
         cnt_q          <= cnt_d;
         last_grant_q   <= last_grant_d;
         mem_addr_q     <= mem_addr_d;
         mem_write_en_q <= mem_write_en_d;
         mem_read_en_q  <= mem_read_en_d;
         if_rdata_q     <= if_rdata_d;
         ls_rdata_q     <= ls_rdata_d;
      end
   end

   assign if_ack       = (state_q == ST_DONE) && (port_q == PORT_IF);
   assign ls_ack       = (state_q == ST_DONE) && (port_q == PORT_LS);
   assign if_rdata     = if_rdata_q;
   assign ls_rdata     = ls_rdata_q;
   assign mem_addr     = mem_addr_q;
   assign mem_write_en = mem_write_en_q;
   assign mem_read_en  = mem_read_en_q;

   assign mem_data = mem_write_en_q ? wdata_q : {DATA_W{1'bz}};

endmodule
